// File: rtl/dp_sum_ctrl.sv
// Moore control unit sequencing the 8-bit register-file/ALU DataPath to compute sum(1..LIMIT).
// Register map: R1 = i, R2 = sum, R3 = constant 1, R4 = limit. R0 always reads as zero.
// The register file has no reset, so every run rebuilds R1..R4 before entering the loop.
module dp_sum_ctrl #(
    parameter int unsigned LIMIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       iLe10,
    output logic       RFSrcMuxSel,
    output logic [2:0] aluOp,
    output logic [2:0] readAddr1,
    output logic [2:0] readAddr2,
    output logic [2:0] writeAddr,
    output logic       writeEn,
    output logic       outBuf,
    output logic       busy,
    output logic       done
);

    // The largest legal LIMIT keeps sum(1..LIMIT) within 8 bits (22 -> 253).
    if (LIMIT < 1 || LIMIT > 22) begin : g_limit_check
        $error("dp_sum_ctrl: LIMIT=%0d outside legal range 1..22", LIMIT);
    end

    localparam int unsigned CntW = $clog2(LIMIT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(LIMIT - 1);

    // ALU opcodes used by this sequence
    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;

    // Register-file addresses
    localparam logic [2:0] RegZero = 3'd0;
    localparam logic [2:0] RegI    = 3'd1;
    localparam logic [2:0] RegSum  = 3'd2;
    localparam logic [2:0] RegOne  = 3'd3;
    localparam logic [2:0] RegLim  = 3'd4;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StInitOne  = 4'd1,
        StClrI     = 4'd2,
        StClrSum   = 4'd3,
        StClrLim   = 4'd4,
        StBuildLim = 4'd5,
        StCmp      = 4'd6,
        StIncI     = 4'd7,
        StAddSum   = 4'd8,
        StOut      = 4'd9,
        StDone     = 4'd10
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] lim_cnt_q, lim_cnt_d;

    // State and limit-counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            lim_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lim_cnt_q <= lim_cnt_d;
        end
    end

    // Next-state logic; R4 is built by adding R3 to itself LIMIT times
    always_comb begin
        state_d   = state_q;
        lim_cnt_d = lim_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInitOne;
                end
            end
            StInitOne: state_d = StClrI;
            StClrI:    state_d = StClrSum;
            StClrSum:  state_d = StClrLim;
            StClrLim: begin
                lim_cnt_d = '0;
                state_d   = StBuildLim;
            end
            StBuildLim: begin
                lim_cnt_d = lim_cnt_q + CntW'(1);
                if (lim_cnt_q == LastCnt) begin
                    state_d = StCmp;
                end
            end
            StCmp: begin
                // iLe10 reports R1 >= R4, i.e. the loop has run LIMIT times
                if (iLe10) begin
                    state_d = StDone;
                end else begin
                    state_d = StIncI;
                end
            end
            StIncI:   state_d = StAddSum;
            StAddSum: state_d = StOut;
            StOut:    state_d = StCmp;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Moore output decode; every field defaults to zero and only the listed ones are driven
    always_comb begin
        RFSrcMuxSel = 1'b0;
        aluOp       = AluAdd;
        readAddr1   = RegZero;
        readAddr2   = RegZero;
        writeAddr   = RegZero;
        writeEn     = 1'b0;
        outBuf      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StInitOne: begin
                RFSrcMuxSel = 1'b1;
                writeAddr   = RegOne;
                writeEn     = 1'b1;
            end
            StClrI: begin
                writeAddr = RegI;
                writeEn   = 1'b1;
            end
            StClrSum: begin
                writeAddr = RegSum;
                writeEn   = 1'b1;
            end
            StClrLim: begin
                writeAddr = RegLim;
                writeEn   = 1'b1;
            end
            StBuildLim: begin
                readAddr1 = RegLim;
                readAddr2 = RegOne;
                writeAddr = RegLim;
                writeEn   = 1'b1;
            end
            StCmp: begin
                aluOp     = AluSub;
                readAddr1 = RegI;
                readAddr2 = RegLim;
            end
            StIncI: begin
                readAddr1 = RegI;
                readAddr2 = RegOne;
                writeAddr = RegI;
                writeEn   = 1'b1;
            end
            StAddSum: begin
                readAddr1 = RegSum;
                readAddr2 = RegI;
                writeAddr = RegSum;
                writeEn   = 1'b1;
            end
            StOut: begin
                // R2 + R0 passes the running sum through the ALU into the output register
                readAddr1 = RegSum;
                outBuf    = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Structural invariants of the sequence
    a_no_r0_write : assert property (@(posedge clk) disable iff (reset)
        writeEn |-> (writeAddr != RegZero));
    a_done_busy : assert property (@(posedge clk) disable iff (reset) done |-> busy);
    a_one_strobe : assert property (@(posedge clk) disable iff (reset) !(writeEn && outBuf));

endmodule

// File: tb/tb_dp_sum_ctrl.sv
// Bench for dp_sum_ctrl: three controllers (LIMIT 10, 1, 22) each drive a behavioural DataPath.
// A per-instance reference tracks the expected running sum, update count and run latency.
module tb_dp_sum_ctrl;

    logic clk;
    logic reset;
    logic start;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 10 : (g == 1) ? 1 : 22;

        logic       sel;
        logic [2:0] alu_op;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [2:0] wa;
        logic       we;
        logic       ob;
        logic       busy;
        logic       done;
        logic       ile;
        logic [16:0] outs;

        logic [7:0] rf [8];
        logic [7:0] rd1, rd2, alu, out_port;
        logic       upd;

        int cur_busy = 0;
        int cur_ups  = 0;
        int ref_i    = 0;
        int ref_sum  = 0;
        int n_runs   = 0;

        dp_sum_ctrl #(.LIMIT(L)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .iLe10      (ile),
            .RFSrcMuxSel(sel),
            .aluOp      (alu_op),
            .readAddr1  (ra1),
            .readAddr2  (ra2),
            .writeAddr  (wa),
            .writeEn    (we),
            .outBuf     (ob),
            .busy       (busy),
            .done       (done)
        );

        assign outs = {sel, alu_op, ra1, ra2, wa, we, ob, busy, done};

        // Behavioural DataPath: combinational reads, R0 hardwired to zero
        always_comb begin
            rd1 = (ra1 == 3'd0) ? 8'd0 : rf[ra1];
            rd2 = (ra2 == 3'd0) ? 8'd0 : rf[ra2];
            case (alu_op)
                3'd0:    alu = rd1 + rd2;
                3'd1:    alu = rd1 - rd2;
                3'd2:    alu = rd1 & rd2;
                3'd3:    alu = rd1 | rd2;
                3'd4:    alu = rd1 ^ rd2;
                3'd5:    alu = ~rd1;
                default: alu = 8'd0;
            endcase
        end
        assign ile = (rd1 >= rd2);

        always @(posedge clk) begin
            if (we) rf[wa] <= sel ? 8'd1 : alu;
            if (ob) out_port <= alu;
            upd <= ob;
        end

        // Reference: the k-th output update must equal 1+2+..+k, a run lasts 5L+6 busy cycles
        always @(negedge clk) begin
            if (reset) begin
                cur_busy = 0;
                cur_ups  = 0;
                ref_i    = 0;
                ref_sum  = 0;
            end else begin
                if (busy) cur_busy++;
                if (upd) begin
                    ref_i++;
                    ref_sum += ref_i;
                    cur_ups++;
                    check_eq($sformatf("L%0d outPort update %0d", L, cur_ups), int'(out_port),
                             ref_sum);
                end
                if (done) begin
                    check_eq($sformatf("L%0d busy cycles to done", L), cur_busy, 5 * L + 6);
                    check_eq($sformatf("L%0d update count", L), cur_ups, L);
                    check_eq($sformatf("L%0d final outPort", L), int'(out_port), L * (L + 1) / 2);
                    n_runs++;
                    cur_busy = 0;
                    cur_ups  = 0;
                    ref_i    = 0;
                    ref_sum  = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse with stray pulses while every instance is still busy
    task automatic run_all(input string tag);
        int r0, r1, r2, cyc;
        r0 = g_inst[0].n_runs;
        r1 = g_inst[1].n_runs;
        r2 = g_inst[2].n_runs;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            start = ($urandom_range(0, 2) == 0);
            tick();
        end
        start = 1'b0;
        cyc = 0;
        while ((g_inst[0].n_runs == r0 || g_inst[1].n_runs == r1 || g_inst[2].n_runs == r2)
               && cyc < 300) begin
            tick();
            cyc++;
        end
        check_eq({tag, " completed in time"}, int'(cyc < 300), 1);
        repeat (3) tick();
        check_eq({tag, " L10 runs"}, g_inst[0].n_runs - r0, 1);
        check_eq({tag, " L1 runs"}, g_inst[1].n_runs - r1, 1);
        check_eq({tag, " L22 runs"}, g_inst[2].n_runs - r2, 1);
        check_eq({tag, " L10 idle after run"}, int'(g_inst[0].busy), 0);
    endtask

    initial begin
        int k, r0, cyc;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        // start during reset must not launch a run
        start = 1'b1;
        tick();
        check_eq("reset outputs L10", int'(g_inst[0].outs), 0);
        check_eq("reset outputs L1", int'(g_inst[1].outs), 0);
        check_eq("reset outputs L22", int'(g_inst[2].outs), 0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        check_eq("idle after reset busy", int'(g_inst[0].busy), 0);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 5)) tick();
            run_all($sformatf("run%0d", r));
        end

        // Reset while the L10 controller is building R4
        start = 1'b1;
        tick();
        start = 1'b0;
        k = $urandom_range(4, 13);
        repeat (k) tick();
        reset = 1'b1;
        tick();
        check_eq("mid-run reset outputs L10", int'(g_inst[0].outs), 0);
        check_eq("mid-run reset outputs L1", int'(g_inst[1].outs), 0);
        check_eq("mid-run reset outputs L22", int'(g_inst[2].outs), 0);
        repeat ($urandom_range(0, 2)) tick();
        reset = 1'b0;
        tick();
        check_eq("after reset release busy", int'(g_inst[2].busy), 0);
        run_all("rerun");

        // Re-pulse while busy, then hold start through DONE for a back-to-back run
        r0 = g_inst[0].n_runs;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 40; c++) begin
            start = $urandom_range(0, 1);
            tick();
        end
        start = 1'b1;
        cyc = 0;
        while (!g_inst[0].done && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("held start done seen", int'(g_inst[0].done), 1);
        tick();
        check_eq("held start idle gap", int'(g_inst[0].busy), 0);
        tick();
        check_eq("held start restart", int'(g_inst[0].busy), 1);
        start = 1'b0;
        cyc = 0;
        while (g_inst[0].n_runs < r0 + 2 && cyc < 100) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        check_eq("back-to-back L10 runs", g_inst[0].n_runs - r0, 2);

        cyc = 0;
        while ((g_inst[0].busy || g_inst[1].busy || g_inst[2].busy) && cyc < 300) begin
            tick();
            cyc++;
        end
        check_eq("all idle at end", int'(cyc < 300), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
